// File: rtl/i2c_apb_regs.sv
// i2c_apb_regs: APB3 register bank in front of the i2c core.
// Holds control, interrupt, address, threshold and bus-timing registers.
module i2c_apb_regs #(
    parameter logic [31:0] TIMING_RST   = 32'd250,
    parameter logic [13:0] DEBOUNCE_RST = 14'd4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [6:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq,
    output logic [7:0]  cr,
    input  logic [7:0]  cr_clr,
    input  logic [6:0]  cr_set,
    input  logic [7:0]  sr,
    input  logic [7:0]  irq_req,
    output logic        tx_fifo_wr,
    output logic [9:0]  tx_fifo_din,
    input  logic [4:0]  tx_fifo_ocy,
    input  logic [4:0]  rx_fifo_ocy,
    output logic        rx_fifo_rd,
    input  logic [7:0]  rx_fifo_dout,
    output logic [6:0]  slv_adr,
    output logic [4:0]  rx_fifo_pirq,
    output logic [13:0] debounce_cnt,
    output logic [31:0] tsusta,
    output logic [31:0] thdsta,
    output logic [31:0] tsusto,
    output logic [31:0] tsudat,
    output logic [31:0] thddat,
    output logic [31:0] tlow,
    output logic [31:0] thigh,
    output logic [31:0] tbuf
);

    localparam logic [4:0] A_GIE   = 5'd0;
    localparam logic [4:0] A_ISR   = 5'd1;
    localparam logic [4:0] A_IER   = 5'd2;
    localparam logic [4:0] A_SOFTR = 5'd3;
    localparam logic [4:0] A_CR    = 5'd4;
    localparam logic [4:0] A_SR    = 5'd5;
    localparam logic [4:0] A_TXF   = 5'd6;
    localparam logic [4:0] A_RXF   = 5'd7;
    localparam logic [4:0] A_ADR   = 5'd8;
    localparam logic [4:0] A_TXO   = 5'd9;
    localparam logic [4:0] A_RXO   = 5'd10;
    localparam logic [4:0] A_PIRQ  = 5'd11;
    localparam logic [4:0] A_DEB   = 5'd12;
    localparam logic [4:0] A_TIM0  = 5'd13;
    localparam logic [4:0] A_TIM7  = 5'd20;

    logic              gie_q, gie_d;
    logic [7:0]        isr_q, isr_d;
    logic [7:0]        ier_q, ier_d;
    logic [7:0]        cr_q, cr_d;
    logic [6:0]        adr_q, adr_d;
    logic [4:0]        pirq_q, pirq_d;
    logic [13:0]       deb_q, deb_d;
    logic [7:0][31:0]  tim_q, tim_d;
    logic              irq_q, irq_d;

    logic              we, re;
    logic [4:0]        widx, toff;
    logic [2:0]        tidx;
    logic              is_tim;
    logic              rd_ok, wr_ok, wr_hit;
    logic [31:0]       rd_val;
    logic              soft_rst;
    logic [7:0]        cr_base, w1c;
    logic              unused_ok;

    assign we        = psel & penable & pwrite;
    assign re        = psel & penable & ~pwrite;
    assign widx      = paddr[6:2];
    assign toff      = widx - A_TIM0;
    assign tidx      = toff[2:0];
    assign is_tim    = (widx >= A_TIM0) && (widx <= A_TIM7);
    assign unused_ok = ^{paddr[1:0], toff[4:3]};

    // Address decode: legality of each direction and the read mux.
    always_comb begin
        rd_ok  = 1'b0;
        wr_ok  = 1'b0;
        rd_val = '0;
        if (is_tim) begin
            rd_ok  = 1'b1;
            wr_ok  = 1'b1;
            rd_val = tim_q[tidx];
        end else begin
            case (widx)
                A_GIE:   begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {gie_q, 31'd0}; end
                A_ISR:   begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {24'd0, isr_q}; end
                A_IER:   begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {24'd0, ier_q}; end
                A_SOFTR: wr_ok = (pwdata[3:0] == 4'hA);
                A_CR:    begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {24'd0, cr_q}; end
                A_SR:    begin rd_ok = 1'b1; rd_val = {24'd0, sr}; end
                A_TXF:   wr_ok = ~sr[4];
                A_RXF:   begin rd_ok = ~sr[6]; rd_val = {24'd0, rx_fifo_dout}; end
                A_ADR:   begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {24'd0, adr_q, 1'b0}; end
                A_TXO:   begin rd_ok = 1'b1; rd_val = {27'd0, tx_fifo_ocy}; end
                A_RXO:   begin rd_ok = 1'b1; rd_val = {27'd0, rx_fifo_ocy}; end
                A_PIRQ:  begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {27'd0, pirq_q}; end
                A_DEB:   begin rd_ok = 1'b1; wr_ok = 1'b1; rd_val = {18'd0, deb_q}; end
                default: ;
            endcase
        end
    end

    assign wr_hit      = we & wr_ok;
    assign soft_rst    = wr_hit && (widx == A_SOFTR);
    assign prdata      = (re && rd_ok) ? rd_val : 32'd0;
    assign pslverr     = (re && !rd_ok) || (we && !wr_ok);
    assign pready      = 1'b1;
    assign tx_fifo_wr  = wr_hit && (widx == A_TXF);
    assign tx_fifo_din = tx_fifo_wr ? pwdata[9:0] : 10'd0;
    assign rx_fifo_rd  = re && rd_ok && (widx == A_RXF);

    // Next register state: bus writes, hardware set/clear, sticky ISR, soft reset.
    always_comb begin
        gie_d   = gie_q;
        ier_d   = ier_q;
        adr_d   = adr_q;
        pirq_d  = pirq_q;
        deb_d   = deb_q;
        tim_d   = tim_q;
        cr_base = (wr_hit && widx == A_CR) ? pwdata[7:0] : cr_q;
        cr_d    = (cr_base & ~cr_clr) | {1'b0, cr_set};
        w1c     = (wr_hit && widx == A_ISR) ? pwdata[7:0] : 8'd0;
        isr_d   = (isr_q & ~w1c) | irq_req;
        irq_d   = gie_q & |(isr_q & ier_q);
        if (wr_hit) begin
            if (is_tim) begin
                tim_d[tidx] = pwdata;
            end else begin
                case (widx)
                    A_GIE:   gie_d  = pwdata[31];
                    A_IER:   ier_d  = pwdata[7:0];
                    A_ADR:   adr_d  = pwdata[7:1];
                    A_PIRQ:  pirq_d = pwdata[4:0];
                    A_DEB:   deb_d  = pwdata[13:0];
                    default: ;
                endcase
            end
        end
        if (soft_rst) begin
            gie_d  = 1'b0;
            isr_d  = 8'd0;
            ier_d  = 8'd0;
            cr_d   = 8'd0;
            adr_d  = 7'd0;
            pirq_d = 5'd0;
            deb_d  = DEBOUNCE_RST;
            tim_d  = {8{TIMING_RST}};
            irq_d  = 1'b0;
        end
    end

    // Register state with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gie_q  <= 1'b0;
            isr_q  <= 8'd0;
            ier_q  <= 8'd0;
            cr_q   <= 8'd0;
            adr_q  <= 7'd0;
            pirq_q <= 5'd0;
            deb_q  <= DEBOUNCE_RST;
            tim_q  <= {8{TIMING_RST}};
            irq_q  <= 1'b0;
        end else begin
            gie_q  <= gie_d;
            isr_q  <= isr_d;
            ier_q  <= ier_d;
            cr_q   <= cr_d;
            adr_q  <= adr_d;
            pirq_q <= pirq_d;
            deb_q  <= deb_d;
            tim_q  <= tim_d;
            irq_q  <= irq_d;
        end
    end

    assign irq          = irq_q;
    assign cr           = cr_q;
    assign slv_adr      = adr_q;
    assign rx_fifo_pirq = pirq_q;
    assign debounce_cnt = deb_q;
    assign tsusta       = tim_q[0];
    assign thdsta       = tim_q[1];
    assign tsusto       = tim_q[2];
    assign tsudat       = tim_q[3];
    assign thddat       = tim_q[4];
    assign tlow         = tim_q[5];
    assign thigh        = tim_q[6];
    assign tbuf         = tim_q[7];

endmodule
